// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD mm:ss countdown timer.
package timer_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_W   = 2 * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_e;

   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'h9;
   localparam logic [BCD_W-1:0]   SEC_WRAP  = 8'h59;

   // Force each nibble into 0..9, then saturate the two-digit value at lim.
   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v,
                                                  input logic [BCD_W-1:0] lim);
      logic [DIGIT_W-1:0] hi;
      logic [DIGIT_W-1:0] lo;
      logic [BCD_W-1:0]   s;
      hi = (v[7:4] > DIGIT_MAX) ? DIGIT_MAX : v[7:4];
      lo = (v[3:0] > DIGIT_MAX) ? DIGIT_MAX : v[3:0];
      s  = {hi, lo};
      return (s > lim) ? lim : s;
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bus between the timer and its host.
interface countdown_timer_if;
   logic       Tick;
   logic       Load;
   logic [7:0] LoadMin;
   logic [7:0] LoadSec;
   logic       StartStop;
   logic [7:0] Min;
   logic [7:0] Sec;
   logic       Running;
   logic       Done;
   logic       Expired;

   modport master (
      output Tick, Load, LoadMin, LoadSec, StartStop,
      input  Min, Sec, Running, Done, Expired
   );

   modport slave (
      input  Tick, Load, LoadMin, LoadSec, StartStop,
      output Min, Sec, Running, Done, Expired
   );
endinterface

// File: rtl/bcd_dec_digit.sv
// One BCD digit of a ripple-borrow decrementer.
module bcd_dec_digit
   import timer_pkg::*;
(
   input  logic [DIGIT_W-1:0] D,
   input  logic               Bin,
   input  logic [DIGIT_W-1:0] Wrap,
   output logic [DIGIT_W-1:0] Q,
   output logic               Bout
);

   always_comb begin
      Q    = D;
      Bout = 1'b0;
      if (Bin) begin
         Bout = (D == 4'd0);
         Q    = Bout ? Wrap : D - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: preset load, run/pause, per-Tick decrement, stop at 00:00.
module countdown_timer
   import timer_pkg::*;
#(
   parameter logic [7:0] MAX_MIN = 8'h99,
   parameter logic [7:0] MAX_SEC = SEC_WRAP
) (
   input  logic                Clk,
   input  logic                Rst_n,
   countdown_timer_if.slave    bus
);

   state_e           state_q, state_d;
   logic [BCD_W-1:0] min_q, min_d, sec_q, sec_d;
   logic [BCD_W-1:0] min_dec, sec_dec;
   logic             done_q, done_d;
   logic             running_q, expired_q;
   logic [3:0]       borrow;
   logic             is_zero, at_one;

   // Ripple borrow chain: sec-ones -> sec-tens -> min-ones -> min-tens.
   bcd_dec_digit u_sec_ones (.D(sec_q[3:0]), .Bin(1'b1),      .Wrap(MAX_SEC[3:0]),
                             .Q(sec_dec[3:0]), .Bout(borrow[0]));
   bcd_dec_digit u_sec_tens (.D(sec_q[7:4]), .Bin(borrow[0]), .Wrap(MAX_SEC[7:4]),
                             .Q(sec_dec[7:4]), .Bout(borrow[1]));
   bcd_dec_digit u_min_ones (.D(min_q[3:0]), .Bin(borrow[1]), .Wrap(DIGIT_MAX),
                             .Q(min_dec[3:0]), .Bout(borrow[2]));
   bcd_dec_digit u_min_tens (.D(min_q[7:4]), .Bin(borrow[2]), .Wrap(DIGIT_MAX),
                             .Q(min_dec[7:4]), .Bout(borrow[3]));

   assign is_zero = ({min_q, sec_q} == 16'h0000);
   assign at_one  = ({min_q, sec_q} == 16'h0001);

   // Next state and count; priority Load > StartStop > Tick.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      done_d  = 1'b0;
      if (bus.Load) begin
         min_d   = bcd_clamp(bus.LoadMin, MAX_MIN);
         sec_d   = bcd_clamp(bus.LoadSec, MAX_SEC);
         state_d = ST_IDLE;
      end else if (bus.StartStop) begin
         case (state_q)
            ST_IDLE:  if (!is_zero) state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end else if (bus.Tick && (state_q == ST_RUN)) begin
         if (at_one) begin
            min_d   = 8'h00;
            sec_d   = 8'h00;
            done_d  = 1'b1;
            state_d = ST_EXPIRED;
         end else if (!borrow[3]) begin
            // final borrow set would mean 00:00; never wrap below zero
            min_d = min_dec;
            sec_d = sec_dec;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= ST_IDLE;
         min_q     <= 8'h00;
         sec_q     <= 8'h00;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         done_q    <= done_d;
         running_q <= (state_d == ST_RUN);
         expired_q <= (state_d == ST_EXPIRED);
      end
   end

   assign bus.Min     = min_q;
   assign bus.Sec     = sec_q;
   assign bus.Running = running_q;
   assign bus.Done    = done_q;
   assign bus.Expired = expired_q;

endmodule
